fp_mul_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor of the team's single-precision combinational multiplier, with these additions:
- configurable exponent and mantissa widths;
- full-width mantissa product with selectable rounding;
- special-value handling and exception flags;
- a valid/ready streaming interface with backpressure.

It sits between operand-fetch logic and result write-back in the FP datapath.

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/fp_mul_pipe_if.sv | 35 +++
 rtl/fp_mant_mul.sv | 23 ++
 rtl/fp_mul_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants, operand classes and format helpers for
//                the parametrised floating-point multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

   // Rounding-mode encodings carried alongside each operand pair
   localparam logic RM_RNE = 1'b0;
   localparam logic RM_RTZ = 1'b1;

   // Bit positions inside the 4-bit flags word {inv, ovf, unf, inx}
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   // Operand / result class; denormals are folded into ZERO
   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   // Exponent bias for a given exponent field width
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB only.
   // Returned in a wide word; callers keep the low 1+exp_w+man_w bits.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << man_w;
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pipe_if
//  Description : Operand / result streaming bundle for fp_mul_pipe.
//                master = operand producer and result consumer,
//                slave  = the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rm;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, rm, out_ready,
      input  in_ready, out_valid, y, flags
   );

   modport slave (
      input  in_valid, a, b, rm, out_ready,
      output in_ready, out_valid, y, flags
   );
endinterface
`default_nettype wire

// File: rtl/fp_mant_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mant_mul
//  Description : Unsigned N x N combinational mantissa multiplier with a full
//                2N-bit product. Kept behind this boundary so an alternative
//                multiplier architecture can be dropped in unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mant_mul #(
   parameter int N = 24
) (
   input  logic [N-1:0]   op_a,
   input  logic [N-1:0]   op_b,
   output logic [2*N-1:0] prod
);

   // Zero-extend both operands so the product is formed at full width
   always_comb begin
      prod = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
   end

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pipe
//  Description : Three-stage pipelined floating-point multiplier with
//                configurable format, RNE/RTZ rounding, special-value
//                handling, exception flags and valid/ready backpressure.
//                S1 classify + exponent sum, S2 mantissa product,
//                S3 normalise / round / pack / flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic          clk,
   input  logic          rst,
   fp_mul_pipe_if.slave  bus
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 1;          // mantissa with hidden bit
   localparam int PW = 2 * MW;             // full product width
   localparam int EW = EXP_W + 2;          // signed working exponent width

   localparam logic signed [EW-1:0]  BIAS_E   = EW'(fp_bias(EXP_W));
   localparam logic signed [EW-1:0]  EMAX     = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0]  EZERO    = '0;
   localparam logic [EXP_W-1:0]      EXP_ONES = '1;
   localparam logic [EXP_W-1:0]      EXP_MAXF = EXP_ONES - EXP_W'(1);
   localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));

   // Field-level classification; a zero exponent means zero (denormal flush)
   function automatic fp_class_e classify(input logic [W-1:0] v);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] f;
      e = v[W-2:MAN_W];
      f = v[MAN_W-1:0];
      if (e == '0)
         return ZERO;
      else if (e == EXP_ONES)
         return (f != '0) ? NAN : INF;
      else
         return NORM;
   endfunction

   // ---------------- pipeline control ----------------
   logic out_valid_r;
   logic advance;

   assign advance      = !out_valid_r | bus.out_ready;
   assign bus.in_ready = advance;

   // ---------------- S1: classify + exponent sum ----------------
   fp_class_e cls_a, cls_b, cls_res;

   // Resolve the result class with NaN/invalid > Inf > zero > normal priority
   always_comb begin
      cls_a = classify(bus.a);
      cls_b = classify(bus.b);
      if (cls_a == NAN || cls_b == NAN ||
          (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
         cls_res = NAN;
      else if (cls_a == INF || cls_b == INF)
         cls_res = INF;
      else if (cls_a == ZERO || cls_b == ZERO)
         cls_res = ZERO;
      else
         cls_res = NORM;
   end

   logic                 s1_valid;
   logic                 s1_sign;
   fp_class_e            s1_cls;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W-1:0]     s1_frac_a;
   logic [MAN_W-1:0]     s1_frac_b;
   logic                 s1_rm;

   // Stage 1 register: capture classified operands and the biased exponent sum
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid  <= bus.in_valid;
         s1_sign   <= bus.a[W-1] ^ bus.b[W-1];
         s1_cls    <= cls_res;
         s1_exp    <= $signed({2'b00, bus.a[W-2:MAN_W]})
                    + $signed({2'b00, bus.b[W-2:MAN_W]}) - BIAS_E;
         s1_frac_a <= bus.a[MAN_W-1:0];
         s1_frac_b <= bus.b[MAN_W-1:0];
         s1_rm     <= bus.rm;
      end
   end

   // ---------------- S2: mantissa product ----------------
   logic [PW-1:0] mant_prod;

   fp_mant_mul #(
      .N (MW)
   ) u_mant_mul (
      .op_a ({1'b1, s1_frac_a}),
      .op_b ({1'b1, s1_frac_b}),
      .prod (mant_prod)
   );

   logic                 s2_valid;
   logic                 s2_sign;
   fp_class_e            s2_cls;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;
   logic                 s2_rm;

   // Stage 2 register: carry the exact product forward with its context
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_cls   <= s1_cls;
         s2_exp   <= s1_exp;
         s2_prod  <= mant_prod;
         s2_rm    <= s1_rm;
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic                 prod_hi;
   logic [PW-1:0]        norm;
   logic [MAN_W-1:0]     frac_t;
   logic                 guard;
   logic                 sticky;
   logic                 round_up;
   logic [MAN_W:0]       frac_sum;
   logic signed [EW-1:0] exp_r;
   logic [W-1:0]         y_next;
   logic [3:0]           flags_next;

   // Normalise so the hidden bit sits at PW-1, round, then range-check
   always_comb begin
      prod_hi  = s2_prod[PW-1];
      norm     = prod_hi ? s2_prod : (s2_prod << 1);
      frac_t   = norm[PW-2 -: MAN_W];
      guard    = norm[PW-2-MAN_W];
      sticky   = |norm[PW-3-MAN_W:0];
      round_up = (s2_rm == RM_RNE) & guard & (sticky | frac_t[0]);
      frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
      // Carry out of the fraction leaves frac_sum[MAN_W-1:0] at zero
      exp_r    = s2_exp + $signed({{(EW-1){1'b0}}, prod_hi})
                        + $signed({{(EW-1){1'b0}}, frac_sum[MAN_W]});

      y_next     = '0;
      flags_next = '0;
      case (s2_cls)
         NAN: begin
            y_next              = QNAN;
            flags_next[FLG_INV] = 1'b1;
         end
         INF: begin
            y_next = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         end
         ZERO: begin
            y_next = {s2_sign, {(W-1){1'b0}}};
         end
         default: begin
            flags_next[FLG_INX] = guard | sticky;
            if (exp_r >= EMAX) begin
               flags_next[FLG_OVF] = 1'b1;
               flags_next[FLG_INX] = 1'b1;
               if (s2_rm == RM_RTZ)
                  y_next = {s2_sign, EXP_MAXF, {MAN_W{1'b1}}};
               else
                  y_next = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            end else if (exp_r <= EZERO) begin
               flags_next[FLG_UNF] = 1'b1;
               flags_next[FLG_INX] = 1'b1;
               y_next              = {s2_sign, {(W-1){1'b0}}};
            end else begin
               y_next = {s2_sign, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
            end
         end
      endcase
   end

   logic [W-1:0] y_r;
   logic [3:0]   flags_r;

   // Output register: holds result and flags steady while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         y_r         <= '0;
         flags_r     <= '0;
      end else if (advance) begin
         out_valid_r <= s2_valid;
         y_r         <= y_next;
         flags_r     <= flags_next;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.y         = y_r;
   assign bus.flags     = flags_r;

endmodule
`default_nettype wire
